// File: rtl/jump_ctrl_pkg.sv
// Shared types and constants for the jump/redirect controller.
// JUMP_MISALIGN_TRAP_EN adds the TRAP state.
package jump_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 21;
  localparam int unsigned JC_W       = 2;

  typedef enum logic [JC_W-1:0] {
    JC_NONE = 2'b00,
    JC_JAL  = 2'b01,
    JC_JALR = 2'b10,
    JC_RSVD = 2'b11
  } jump_ctrl_e;

`ifdef JUMP_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_RS1_WAIT, S_REDIRECT, S_LINK, S_TRAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RS1_WAIT, S_REDIRECT, S_LINK} state_e;
`endif

  // Instruction layout: {imm[20:1], rs1, rd, jump_control}; imm[0] is always 0.
  typedef struct packed {
    logic [IMM_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rd;
    jump_ctrl_e            jc;
  } jump_dec_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/jump_redirect_ctrl_decode.sv
// Field extraction for jump instructions (module decode_jump_inst).
module decode_jump_inst
  import jump_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output jump_dec_t       dec_c_o
);

  always_comb begin
    dec_c_o.jc  = jump_ctrl_e'(instr_i[1:0]);
    dec_c_o.rd  = instr_i[6:2];
    dec_c_o.rs1 = instr_i[11:7];
    dec_c_o.imm = {instr_i[31:12], 1'b0};
  end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// JAL/JALR controller: operand fetch, fetch redirect with flush, link writeback.
// Optional JUMP_MISALIGN_TRAP_EN: misaligned targets raise a one-cycle trap instead.
module jump_redirect_ctrl
  import jump_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [XLEN-1:0]       instr,
  input  logic [XLEN-1:0]       pc,
  output logic                  rs1_rd_en,
  output logic [REG_ADDR_W-1:0] rs1_rd_addr,
  input  logic                  rs1_data_valid,
  input  logic [XLEN-1:0]       rs1_data,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  input  logic                  redirect_ack,
  output logic                  flush,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  busy
`ifdef JUMP_MISALIGN_TRAP_EN
  ,
  output logic                  trap_valid,
  output logic [XLEN-1:0]       trap_tval
`endif
);

  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  state_e                state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d, target_q, target_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d;
  logic [IMM_W-1:0]      imm_q, imm_d;
  logic                  go_tgt;
  jump_dec_t             dec;

  logic                  instr_ready_q, busy_q, rs1_rd_en_q, redirect_valid_q, flush_q, wb_en_q;
  logic [REG_ADDR_W-1:0] rs1_rd_addr_q, wb_rd_q;
  logic [XLEN-1:0]       redirect_pc_q, wb_data_q;

  decode_jump_inst u_dec (
    .instr_i (instr),
    .dec_c_o (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      target_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      imm_q    <= imm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    imm_d    = imm_q;
    go_tgt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          unique case (dec.jc)
            JC_JAL: begin
              pc_d     = pc;
              rd_d     = dec.rd;
              target_d = pc + sext_imm(dec.imm);
              go_tgt   = 1'b1;
            end
            JC_JALR: begin
              pc_d  = pc;
              rd_d  = dec.rd;
              rs1_d = dec.rs1;
              imm_d = dec.imm;
              // x0 base needs no register read
              if (dec.rs1 != '0) begin
                state_d = S_RS1_WAIT;
              end else begin
                target_d = sext_imm(dec.imm) & JALR_MASK;
                go_tgt   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_RS1_WAIT: begin
        if (rs1_data_valid) begin
          target_d = (rs1_data + sext_imm(imm_q)) & JALR_MASK;
          go_tgt   = 1'b1;
        end
      end
      S_REDIRECT: begin
        if (redirect_ack) state_d = (rd_q != '0) ? S_LINK : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_tgt) state_d = S_REDIRECT;
`ifdef JUMP_MISALIGN_TRAP_EN
    if (go_tgt && target_d[1]) state_d = S_TRAP;
`endif
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ready_q    <= 1'b1;
      busy_q           <= 1'b0;
      rs1_rd_en_q      <= 1'b0;
      rs1_rd_addr_q    <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      wb_en_q          <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
    end else begin
      instr_ready_q    <= (state_d == S_IDLE);
      busy_q           <= (state_d != S_IDLE);
      rs1_rd_en_q      <= (state_d == S_RS1_WAIT);
      rs1_rd_addr_q    <= (state_d == S_RS1_WAIT) ? rs1_d : '0;
      redirect_valid_q <= (state_d == S_REDIRECT);
      redirect_pc_q    <= (state_d == S_REDIRECT) ? target_d : '0;
      flush_q          <= (state_d == S_REDIRECT) && (state_q != S_REDIRECT);
      wb_en_q          <= (state_d == S_LINK);
      wb_rd_q          <= (state_d == S_LINK) ? rd_d : '0;
      wb_data_q        <= (state_d == S_LINK) ? (pc_d + XLEN'(4)) : '0;
    end
  end

`ifdef JUMP_MISALIGN_TRAP_EN
  logic            trap_valid_q;
  logic [XLEN-1:0] trap_tval_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_valid_q <= 1'b0;
      trap_tval_q  <= '0;
    end else begin
      trap_valid_q <= (state_d == S_TRAP);
      trap_tval_q  <= (state_d == S_TRAP) ? target_d : '0;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_tval  = trap_tval_q;
`endif

  assign instr_ready    = instr_ready_q;
  assign busy           = busy_q;
  assign rs1_rd_en      = rs1_rd_en_q;
  assign rs1_rd_addr    = rs1_rd_addr_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Randomized self-checking bench for jump_redirect_ctrl against a per-cycle phase model.
module tb_jump_redirect_ctrl;

`ifdef JUMP_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0, rs1_data_valid = 1'b0, redirect_ack = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0;
  logic        instr_ready, rs1_rd_en, redirect_valid, flush, wb_en, busy;
  logic [4:0]  rs1_rd_addr, wb_rd;
  logic [31:0] redirect_pc, wb_data;
  logic        trap_valid;
  logic [31:0] trap_tval;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jump_redirect_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc),
    .rs1_rd_en(rs1_rd_en), .rs1_rd_addr(rs1_rd_addr),
    .rs1_data_valid(rs1_data_valid), .rs1_data(rs1_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
    .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy)
`ifdef JUMP_MISALIGN_TRAP_EN
    , .trap_valid(trap_valid), .trap_tval(trap_tval)
`endif
  );

`ifndef JUMP_MISALIGN_TRAP_EN
  assign trap_valid = 1'b0;
  assign trap_tval  = '0;
`endif

  typedef struct packed {
    logic        rdy;
    logic        busy;
    logic        rden;
    logic [4:0]  ra;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic        wb;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        tv;
    logic [31:0] tt;
  } out_t;

  typedef enum {K_IDLE, K_WAIT, K_RED, K_LINK, K_TRAP} kind_e;

  out_t obs_q[$];
  out_t exp_q[$];

  function automatic out_t sample();
    out_t o;
    o = '{rdy: instr_ready, busy: busy, rden: rs1_rd_en, ra: rs1_rd_addr, rv: redirect_valid,
          rpc: redirect_pc, fl: flush, wb: wb_en, wrd: wb_rd, wd: wb_data, tv: trap_valid, tt: trap_tval};
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("rdy=%b busy=%b rden=%b ra=%0d rv=%b rpc=%h fl=%b wb=%b wrd=%0d wd=%h tv=%b tt=%h",
                     o.rdy, o.busy, o.rden, o.ra, o.rv, o.rpc, o.fl, o.wb, o.wrd, o.wd, o.tv, o.tt);
  endfunction

  function automatic logic [31:0] sx(input logic [20:0] v);
    return {{11{v[20]}}, v};
  endfunction

  function automatic logic [31:0] enc(input logic [1:0] jc, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [20:0] imm);
    return {imm[20:1], rs1, rd, jc};
  endfunction

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  // One instruction from acceptance cycle to its last busy cycle; appends observed/expected.
  task automatic run_txn(input logic [31:0] tpc, input logic [1:0] jc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [20:0] imm, input logic [31:0] rdata,
                         input int lat, input int ackd);
    kind_e       k[$];
    logic [31:0] tgt;
    out_t        e;
    bit          last;
    k.push_back(K_IDLE);
    if (jc == 2'b01) tgt = tpc + sx(imm);
    else             tgt = (((rs1 == 5'd0) ? 32'd0 : rdata) + sx(imm)) & 32'hFFFF_FFFE;
    if (jc == 2'b01 || jc == 2'b10) begin
      if (jc == 2'b10 && rs1 != 5'd0) repeat (lat) k.push_back(K_WAIT);
      if (TRAP_EN && tgt[1]) k.push_back(K_TRAP);
      else begin
        repeat (ackd + 1) k.push_back(K_RED);
        if (rd != 5'd0) k.push_back(K_LINK);
      end
    end
    for (int c = 0; c < k.size(); c++) begin
      @(negedge clk);
      obs_q.push_back(sample());
      e = '0;
      e.busy = (k[c] != K_IDLE);
      case (k[c])
        K_IDLE: e.rdy = 1'b1;
        K_WAIT: begin e.rden = 1'b1; e.ra = rs1; end
        K_RED:  begin e.rv = 1'b1; e.rpc = tgt; e.fl = (k[c-1] != K_RED); end
        K_LINK: begin e.wb = 1'b1; e.wrd = rd; e.wd = tpc + 32'd4; end
        K_TRAP: begin e.tv = 1'b1; e.tt = tgt; end
        default: ;
      endcase
      exp_q.push_back(e);
      last = (c + 1 == k.size()) || (k[c+1] != k[c]);
      instr_valid    = (c == 0) ? 1'b1 : 1'($urandom_range(1));
      instr          = (c == 0) ? enc(jc, rd, rs1, imm) : $urandom;
      pc             = (c == 0) ? tpc : $urandom;
      rs1_data_valid = (k[c] == K_WAIT) ? last : 1'($urandom_range(1));
      rs1_data       = (k[c] == K_WAIT && last) ? rdata : $urandom;
      redirect_ack   = (k[c] == K_RED) ? last : 1'($urandom_range(1));
    end
  endtask

  task automatic quiet_inputs();
    instr_valid = 1'b0; rs1_data_valid = 1'b0; redirect_ack = 1'b0;
    instr = '0; pc = '0; rs1_data = '0;
  endtask

  task automatic test_reset();
    out_t o;
    rst = 1'b1;
    #3;
    o = sample();
    n_cmp++;
    if (o !== idle_out()) begin
      n_fail++; $display("FAIL reset_async got %s want %s", fmt(o), fmt(idle_out()));
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    o = sample();
    n_cmp++;
    if (o !== idle_out()) begin
      n_fail++; $display("FAIL reset_release got %s want %s", fmt(o), fmt(idle_out()));
    end
  endtask

  task automatic test_directed();
    obs_q = {}; exp_q = {};
    run_txn(32'h0000_1000, 2'b01, 5'd1, 5'd0, 21'h00010, 32'h0, 1, 0);          // JAL, immediate ack
    run_txn(32'h0000_3000, 2'b10, 5'd0, 5'd5, 21'h1FFFFC, 32'h0000_2003, 3, 0); // JALR rs1=5 imm=-4
    run_txn(32'h0000_0200, 2'b01, 5'd7, 5'd0, 21'h00040, 32'h0, 1, 4);          // delayed ack
    run_txn(32'h0000_0000, 2'b11, 5'd3, 5'd4, 21'h00008, 32'h0, 1, 0);          // reserved
    run_txn(32'h0000_0000, 2'b00, 5'd3, 5'd4, 21'h00008, 32'h0, 1, 0);          // none
    run_txn(32'hFFFF_FFFC, 2'b01, 5'd2, 5'd0, 21'h00008, 32'h0, 1, 1);          // wrap
    run_txn(32'h0000_0100, 2'b01, 5'd1, 5'd0, 21'h00002, 32'h0, 1, 0);          // target bit1
    run_txn(32'h0000_0500, 2'b10, 5'd9, 5'd0, 21'h00124, 32'hDEAD_BEEF, 1, 2);  // JALR x0 base
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL directed cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rd, rs1;
    logic [20:0] imm;
    obs_q = {}; exp_q = {};
    for (int t = 0; t < 80; t++) begin
      rd  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      rs1 = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      imm = 21'($urandom) & 21'h1FFFFE;
      run_txn($urandom, 2'($urandom), rd, rs1, imm, $urandom,
              int'($urandom_range(4, 1)), int'($urandom_range(3)));
    end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t o, e;
    // JALR parked in the operand wait
    @(negedge clk);
    quiet_inputs();
    instr_valid = 1'b1; instr = enc(2'b10, 5'd2, 5'd7, 21'd8); pc = 32'h40;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    o = sample();
    e = '0; e.busy = 1'b1; e.rden = 1'b1; e.ra = 5'd7;
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL rst_wait_pre got %s want %s", fmt(o), fmt(e)); end
    #1 rst = 1'b1;
    #1 o = sample();
    n_cmp++;
    if (o !== idle_out()) begin n_fail++; $display("FAIL rst_wait_async got %s want %s", fmt(o), fmt(idle_out())); end
    rs1_data_valid = 1'b1; rs1_data = 32'h1000; redirect_ack = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = sample();
      n_cmp++;
      if (o !== idle_out()) begin n_fail++; $display("FAIL rst_wait_after%0d got %s want %s", c, fmt(o), fmt(idle_out())); end
    end
    // JAL parked in redirect awaiting ack
    quiet_inputs();
    instr_valid = 1'b1; instr = enc(2'b01, 5'd4, 5'd0, 21'h20); pc = 32'h800;
    @(negedge clk);
    instr_valid = 1'b0;
    o = sample();
    e = '0; e.busy = 1'b1; e.rv = 1'b1; e.rpc = 32'h820; e.fl = 1'b1;
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL rst_red_pre got %s want %s", fmt(o), fmt(e)); end
    #1 rst = 1'b1;
    #1 o = sample();
    n_cmp++;
    if (o !== idle_out()) begin n_fail++; $display("FAIL rst_red_async got %s want %s", fmt(o), fmt(idle_out())); end
    redirect_ack = 1'b1; rs1_data_valid = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = sample();
      n_cmp++;
      if (o !== idle_out()) begin n_fail++; $display("FAIL rst_red_after%0d got %s want %s", c, fmt(o), fmt(idle_out())); end
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    quiet_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
